// File: rtl/chebyshev_recursion_if.sv
// Term stream from the Chebyshev generator: one T_k value and its index per
// valid/ready handshake.
interface chebyshev_recursion_if #(
  parameter int WL    = 16,
  parameter int ORD_W = 4
);
  logic [WL-1:0]    t_out;
  logic [ORD_W-1:0] t_idx;
  logic             t_valid;
  logic             t_ready;

  modport master (output t_out, t_idx, t_valid, input t_ready);
  modport slave  (input t_out, t_idx, t_valid, output t_ready);
endinterface

// File: rtl/chebyshev_recursion.sv
// Iterative Chebyshev generator: streams T_0(x)..T_order(x) using
// T_{k+1} = 2*x*T_k - T_{k-1}, saturating each term to WL-bit fixed point.
//
// state | meaning
// IDLE  | waiting for start; x/order latched on start
// EMIT  | T_k presented on the stream, held until accepted
// CALC  | one-cycle bubble computing T_{k+1}
module chebyshev_recursion #(
  parameter int WL     = 16,
  parameter int I_BITS = 6,
  parameter int ORD_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WL-1:0]         x_in,
  input  logic [ORD_W-1:0]      order,
  output logic                  busy,
  output logic                  ovf,
  output logic                  done,
  chebyshev_recursion_if.master t_bus
);

  localparam int FRAC = WL - I_BITS;
  localparam logic [WL-1:0] ONE   = {{(WL-1){1'b0}}, 1'b1} << FRAC;
  localparam logic [WL-1:0] S_MAX = {1'b0, {(WL-1){1'b1}}};
  localparam logic [WL-1:0] S_MIN = {1'b1, {(WL-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, EMIT, CALC} state_t;

  state_t                  state, state_next;
  logic [WL-1:0]           x_reg, tk, tkm1, next_t;
  logic [ORD_W-1:0]        k, order_reg;
  logic signed [2*WL-1:0]  prod, twice;
  logic [2*WL:0]           diff;
  logic                    sat_hit, hs, last;

  // 2*x*T_k is the full product shifted by FRAC-1, floor rounding via >>>
  always_comb begin
    prod    = {{WL{x_reg[WL-1]}}, x_reg} * {{WL{tk[WL-1]}}, tk};
    twice   = prod >>> (FRAC - 1);
    diff    = {twice[2*WL-1], twice} - {{(WL+1){tkm1[WL-1]}}, tkm1};
    sat_hit = !((&diff[2*WL:WL-1]) || !(|diff[2*WL:WL-1]));
    if (k == '0)
      next_t = x_reg;
    else if (sat_hit)
      next_t = diff[2*WL] ? S_MIN : S_MAX;
    else
      next_t = diff[WL-1:0];
  end

  assign hs   = (state == EMIT) && t_bus.t_ready;
  assign last = (k == order_reg);

  always_comb begin
    state_next    = state;
    busy          = 1'b0;
    t_bus.t_valid = 1'b0;
    t_bus.t_out   = tk;
    t_bus.t_idx   = k;
    case (state)
      IDLE: begin
        if (start) state_next = EMIT;
      end
      EMIT: begin
        busy          = 1'b1;
        t_bus.t_valid = 1'b1;
        if (hs) state_next = last ? IDLE : CALC;
      end
      CALC: begin
        busy       = 1'b1;
        state_next = EMIT;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      x_reg     <= '0;
      tk        <= '0;
      tkm1      <= '0;
      k         <= '0;
      order_reg <= '0;
      ovf       <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_next;
      done  <= hs && last;
      case (state)
        IDLE: begin
          if (start) begin
            x_reg     <= x_in;
            order_reg <= order;
            tk        <= ONE;
            tkm1      <= '0;
            k         <= '0;
            ovf       <= 1'b0;
          end
        end
        CALC: begin
          tkm1 <= tk;
          tk   <= next_t;
          k    <= k + 1'b1;
          if (k != '0 && sat_hit) ovf <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chebyshev_recursion.sv
// Directed bench for chebyshev_recursion: table of operands with hand-computed
// terms, plus stall, re-start and mid-run reset sequences.
module tb_chebyshev_recursion;

  typedef struct packed {
    logic [15:0]      x;
    logic [3:0]       ord;
    logic [0:3][15:0] t;
    logic             ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] x_in;
  logic [3:0]  order;
  logic        busy, ovf, done;

  int n_vec  = 0;
  int n_fail = 0;
  vec_t vecs[9];

  chebyshev_recursion_if #(.WL(16), .ORD_W(4)) bus ();

  chebyshev_recursion #(.WL(16), .I_BITS(6), .ORD_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x_in  (x_in),
    .order (order),
    .busy  (busy),
    .ovf   (ovf),
    .done  (done),
    .t_bus (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [15:0] x, input logic [3:0] ord,
                         input logic [15:0] t0, input logic [15:0] t1,
                         input logic [15:0] t2, input logic [15:0] t3, input logic o);
    vecs[i].x    = x;
    vecs[i].ord  = ord;
    vecs[i].t[0] = t0;
    vecs[i].t[1] = t1;
    vecs[i].t[2] = t2;
    vecs[i].t[3] = t3;
    vecs[i].ovf  = o;
  endtask

  // j counts clock edges since the start edge; T_k should appear at j = 1 + 2k
  // when never stalled, and 2 edges after the previous handshake in general.
  task automatic run_vec(input vec_t v, input int stall_k, input int stall_n, input int pulse_k);
    int j, exp_j, budget;
    @(negedge clk);
    x_in = v.x; order = v.ord; start = 1'b1; bus.t_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; j = 1; exp_j = 1;
    chk("busy_after_start", busy, 1);
    for (int kk = 0; kk <= int'(v.ord); kk++) begin
      budget = 0;
      while (!bus.t_valid && budget < 20) begin
        @(negedge clk);
        start = 1'b0; j++; budget++;
      end
      chk("valid_seen", bus.t_valid, 1);
      chk("term_timing", j, exp_j);
      chk("t_out", bus.t_out, v.t[kk]);
      chk("t_idx", bus.t_idx, kk);
      if (kk == 0) chk("ovf_cleared", ovf, 0);
      if (kk == pulse_k) begin
        start = 1'b1; x_in = 16'h0100;
      end
      if (kk == stall_k) begin
        bus.t_ready = 1'b0;
        repeat (stall_n) begin
          @(negedge clk);
          start = 1'b0; j++;
          chk("stall_valid", bus.t_valid, 1);
          chk("stall_t_out", bus.t_out, v.t[kk]);
          chk("stall_t_idx", bus.t_idx, kk);
        end
        bus.t_ready = 1'b1;
      end
      exp_j = j + 2;
      @(negedge clk);
      start = 1'b0; j++;
      if (kk < int'(v.ord)) begin
        chk("bubble", bus.t_valid, 0);
        chk("no_early_done", done, 0);
      end else begin
        chk("done_pulse", done, 1);
        chk("busy_low_at_done", busy, 0);
        chk("final_ovf", ovf, v.ovf);
        chk("valid_low_at_done", bus.t_valid, 0);
      end
    end
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    set_vec(0, 16'h0200, 4'd3, 16'h0400, 16'h0200, 16'hFE00, 16'hFC00, 1'b0);
    set_vec(1, 16'h2000, 4'd3, 16'h0400, 16'h2000, 16'h7FFF, 16'h7FFF, 1'b1);
    set_vec(2, 16'h1234, 4'd0, 16'h0400, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    set_vec(3, 16'hFE00, 4'd3, 16'h0400, 16'hFE00, 16'hFE00, 16'h0400, 1'b0);
    set_vec(4, 16'hE000, 4'd3, 16'h0400, 16'hE000, 16'h7FFF, 16'h8000, 1'b1);
    set_vec(5, 16'h0101, 4'd3, 16'h0400, 16'h0101, 16'hFC81, 16'hFD3D, 1'b0);
    set_vec(6, 16'h0300, 4'd3, 16'h0400, 16'h0300, 16'h0080, 16'hFDC0, 1'b0);
    set_vec(7, 16'h0400, 4'd2, 16'h0400, 16'h0400, 16'h0400, 16'h0000, 1'b0);
    set_vec(8, 16'h7FFF, 4'd1, 16'h0400, 16'h7FFF, 16'h0000, 16'h0000, 1'b0);

    rst_n = 1'b0; start = 1'b0; x_in = '0; order = '0; bus.t_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", bus.t_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_t_out", bus.t_out, 0);
    chk("rst_t_idx", bus.t_idx, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], -1, 0, -1);

    run_vec(vecs[0], 2, 5, -1);
    run_vec(vecs[0], -1, 0, 1);

    // reset while in the bubble after T_1 was accepted
    @(negedge clk);
    x_in = 16'h0200; order = 4'd3; start = 1'b1; bus.t_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort_t0", bus.t_out, 16'h0400);
    @(negedge clk);
    @(negedge clk);
    chk("abort_t1", bus.t_out, 16'h0200);
    chk("abort_t1_idx", bus.t_idx, 1);
    @(negedge clk);
    chk("abort_in_calc", bus.t_valid, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_valid", bus.t_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ovf", ovf, 0);
    chk("abort_t_out", bus.t_out, 0);
    chk("abort_t_idx", bus.t_idx, 0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
      chk("abort_idle", busy, 0);
    end
    run_vec(vecs[0], -1, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
